// File: rtl/i2c_cfg_sequencer.sv
// rtl/i2c_cfg_sequencer.sv - table-driven I2C register write sequencer
// Walks LUT_SIZE entries, writes each as one I2C transfer, retries NACKs.
module i2c_cfg_sequencer #(
    parameter int CLK_FREQ    = 50000000,
    parameter int I2C_FREQ    = 20000,
    parameter int LUT_SIZE    = 51,
    parameter int ADDR_BYTES  = 1,
    parameter int DATA_BYTES  = 1,
    parameter int MAX_RETRY   = 3,
    parameter int SKIP_ON_ERR = 0
) (
    input  logic                                    iCLK,
    input  logic                                    iRST,
    input  logic                                    iSTART,
    output logic [7:0]                              oLUT_INDEX,
    input  logic [8+8*(ADDR_BYTES+DATA_BYTES)-1:0]  iLUT_DATA,
    output logic                                    oBUSY,
    output logic                                    oDONE,
    output logic                                    oERR,
    output logic [7:0]                              oERR_INDEX,
    output logic                                    oI2C_SCLK,
    output logic                                    oSDA_OE,
    input  logic                                    iSDA
);
    localparam int ENTRY_W   = 8 + 8 * (ADDR_BYTES + DATA_BYTES);
    localparam int NUM_BYTES = 1 + ADDR_BYTES + DATA_BYTES;
    localparam int Q_RAW     = CLK_FREQ / (4 * I2C_FREQ);
    localparam int Q         = (Q_RAW < 1) ? 1 : Q_RAW;
    localparam int DIV_W     = $clog2(Q + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_START, S_SHIFT, S_ACK, S_STOP, S_GAP
    } state_t;

    state_t               state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [1:0]           phase_q, phase_d;
    logic [2:0]           bit_q, bit_d;
    logic [2:0]           byte_q, byte_d;
    logic [ENTRY_W-1:0]   shreg_q, shreg_d;
    logic [4:0]           retry_q, retry_d;
    logic                 nack_q, nack_d;
    logic                 auto_q, auto_d;
    logic [7:0]           index_q, index_d;
    logic [7:0]           err_index_q, err_index_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 scl_q, scl_d;
    logic                 sda_oe_q, sda_oe_d;
    logic                 ticking;
    logic                 tick;

    assign ticking = (state_q != S_IDLE) && (state_q != S_FETCH);
    assign tick    = ticking && (div_q == DIV_W'(Q - 1));

    always_comb begin
        state_d     = state_q;
        div_d       = '0;
        phase_d     = phase_q;
        bit_d       = bit_q;
        byte_d      = byte_q;
        shreg_d     = shreg_q;
        retry_d     = retry_q;
        nack_d      = nack_q;
        auto_d      = 1'b0;
        index_d     = index_q;
        err_index_d = err_index_q;
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;
        scl_d       = scl_q;
        sda_oe_d    = sda_oe_q;

        if (ticking) begin
            div_d = tick ? '0 : div_q + 1'b1;
        end
        if (tick) begin
            phase_d = phase_q + 2'd1;
        end

        case (state_q)
            S_IDLE: begin
                // Auto-start after reset behaves exactly like a host iSTART.
                if (iSTART || auto_q) begin
                    done_d      = 1'b0;
                    err_d       = 1'b0;
                    err_index_d = 8'd0;
                    index_d     = 8'd0;
                    retry_d     = 5'd0;
                    busy_d      = 1'b1;
                    state_d     = S_FETCH;
                end
            end
            S_FETCH: begin
                shreg_d              = iLUT_DATA;
                shreg_d[ENTRY_W-8]   = 1'b0;
                phase_d              = 2'd0;
                bit_d                = 3'd0;
                byte_d               = 3'd0;
                nack_d               = 1'b0;
                state_d              = S_START;
            end
            S_START: if (tick) begin
                if (phase_q == 2'd1) sda_oe_d = 1'b1;
                if (phase_q == 2'd3) begin
                    scl_d   = 1'b0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: if (tick) begin
                case (phase_q)
                    2'd0: sda_oe_d = ~shreg_q[ENTRY_W-1];
                    2'd1: scl_d    = 1'b1;
                    2'd3: begin
                        scl_d   = 1'b0;
                        shreg_d = shreg_q << 1;
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = S_ACK;
                    end
                    default: ;
                endcase
            end
            S_ACK: if (tick) begin
                case (phase_q)
                    2'd0: sda_oe_d = 1'b0;
                    2'd1: scl_d    = 1'b1;
                    2'd2: nack_d   = iSDA;
                    default: begin
                        scl_d  = 1'b0;
                        byte_d = byte_q + 3'd1;
                        if (nack_q || byte_q == 3'(NUM_BYTES - 1)) state_d = S_STOP;
                        else                                       state_d = S_SHIFT;
                    end
                endcase
            end
            S_STOP: if (tick) begin
                case (phase_q)
                    2'd0: sda_oe_d = 1'b1;
                    2'd1: scl_d    = 1'b1;
                    2'd2: sda_oe_d = 1'b0;
                    default: state_d = S_GAP;
                endcase
            end
            S_GAP: if (tick && phase_q == 2'd3) begin
                retry_d = retry_q + 5'd1;
                state_d = S_FETCH;
                if (!nack_q || retry_q >= 5'(MAX_RETRY)) begin
                    if (nack_q) begin
                        err_d = 1'b1;
                        if (!err_q) err_index_d = index_q;
                    end
                    retry_d = 5'd0;
                    if ((nack_q && SKIP_ON_ERR == 0) || index_q == 8'(LUT_SIZE - 1)) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        index_d = index_q + 8'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            phase_q     <= 2'd0;
            bit_q       <= 3'd0;
            byte_q      <= 3'd0;
            shreg_q     <= '0;
            retry_q     <= 5'd0;
            nack_q      <= 1'b0;
            auto_q      <= 1'b1;
            index_q     <= 8'd0;
            err_index_q <= 8'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            scl_q       <= 1'b1;
            sda_oe_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            phase_q     <= phase_d;
            bit_q       <= bit_d;
            byte_q      <= byte_d;
            shreg_q     <= shreg_d;
            retry_q     <= retry_d;
            nack_q      <= nack_d;
            auto_q      <= auto_d;
            index_q     <= index_d;
            err_index_q <= err_index_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            scl_q       <= scl_d;
            sda_oe_q    <= sda_oe_d;
        end
    end

    assign oLUT_INDEX = index_q;
    assign oBUSY      = busy_q;
    assign oDONE      = done_q;
    assign oERR       = err_q;
    assign oERR_INDEX = err_index_q;
    assign oI2C_SCLK  = scl_q;
    assign oSDA_OE    = sda_oe_q;
endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// tb/tb_i2c_cfg_sequencer.sv - directed bench for i2c_cfg_sequencer
// Four instances: nominal 1+1 (retry/restart/reset), halt on error, skip on error, 2+2 width.
module tb_i2c_cfg_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] rst   = 4'hF;
    logic [3:0] start = 4'h0;
    logic [3:0] done_v, busy_v, err_v;
    int n_assert = 0;
    int n_fail   = 0;
    int nack_lo [4] = '{1, 2, 2, 1};
    int nack_hi [4] = '{0, 1000, 4, 0};

    for (genvar g = 0; g < 4; g++) begin : gen_dut
        localparam int AB  = (g == 3) ? 2 : 1;
        localparam int W   = 8 + 16 * AB;
        localparam int LSZ = (g == 3) ? 1 : 3;
        localparam int MR  = (g == 0) ? 3 : 2;
        localparam int SK  = (g == 2) ? 1 : 0;

        logic [7:0]   idx, err_index;
        logic [W-1:0] lut;
        logic         busy, done, err, scl, sda_oe, sda;
        logic         pull = 1'b0;
        logic         prev_scl = 1'b1, prev_sda = 1'b1, in_ack = 1'b0;
        logic [7:0]   sh = 8'h00;
        logic [7:0]   log_b [256];
        int           start_n = 0, byte_n = 0, ack_n = 0, bit_n = 0, xb = 0;

        assign sda       = ~(sda_oe | pull);
        assign done_v[g] = done;
        assign busy_v[g] = busy;
        assign err_v[g]  = err;

        always_comb begin
            lut = '0;
            if (g == 3) lut = W'(40'h42_1234_ABCD);
            else begin
                case (idx)
                    8'd0:    lut = W'(24'h34_00_18);
                    8'd1:    lut = W'(24'h35_02_77);
                    default: lut = W'(24'h40_C3_01);
                endcase
            end
        end

        // Slave model: decodes bytes, ACKs unless this START falls in the NACK window.
        always @(negedge clk) begin
            if (scl && prev_scl && prev_sda && !sda) begin
                start_n++;
                bit_n  = 0;
                xb     = 0;
                in_ack = 1'b0;
                pull   = 1'b0;
            end else if (scl && !prev_scl) begin
                if (bit_n < 8) begin
                    sh = {sh[6:0], sda};
                    bit_n++;
                    if (bit_n == 8) begin
                        log_b[byte_n[7:0]] = sh;
                        byte_n++;
                    end
                end else begin
                    if (sda == 1'b0) ack_n++;
                    in_ack = 1'b1;
                end
            end else if (!scl && prev_scl) begin
                if (in_ack) begin
                    pull   = 1'b0;
                    in_ack = 1'b0;
                    bit_n  = 0;
                    xb++;
                end else if (bit_n == 8) begin
                    pull = !((xb == 0) && (start_n >= nack_lo[g]) && (start_n <= nack_hi[g]));
                end
            end
            prev_scl = scl;
            prev_sda = sda;
        end

        i2c_cfg_sequencer #(
            .CLK_FREQ(800000), .I2C_FREQ(100000), .LUT_SIZE(LSZ),
            .ADDR_BYTES(AB), .DATA_BYTES(AB), .MAX_RETRY(MR), .SKIP_ON_ERR(SK)
        ) u_dut (
            .iCLK(clk), .iRST(rst[g]), .iSTART(start[g]),
            .oLUT_INDEX(idx), .iLUT_DATA(lut),
            .oBUSY(busy), .oDONE(done), .oERR(err), .oERR_INDEX(err_index),
            .oI2C_SCLK(scl), .oSDA_OE(sda_oe), .iSDA(sda)
        );
    end

    logic [7:0] exp_nom [9] = '{8'h34, 8'h00, 8'h18, 8'h34, 8'h02, 8'h77, 8'h40, 8'hC3, 8'h01};
    logic [7:0] exp_wide [5] = '{8'h42, 8'h12, 8'h34, 8'hAB, 8'hCD};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int g, input int budget, output int cyc);
        cyc = 0;
        while (done_v[g] !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check($sformatf("done_reached_%0d", g), done_v[g], 1'b1);
    endtask

    initial begin
        int cyc, sb, bb, ab;
        repeat (3) @(negedge clk);
        check("rst_flags", {busy_v[0], done_v[0], err_v[0], gen_dut[0].scl, gen_dut[0].sda_oe}, 5'b00010);
        check("rst_index", {gen_dut[0].idx, gen_dut[0].err_index}, 16'h0000);

        rst = 4'h0;
        @(negedge clk);
        check("auto_start_busy", busy_v, 4'hF);

        wait_done(0, 2000, cyc);
        n_assert++;
        assert (cyc + 1 >= 721 && cyc + 1 <= 725) else begin
            n_fail++;
            $error("FAIL nom_done_cycle: observed %0d expected 723+-2", cyc + 1);
        end
        check("nom_err", err_v[0], 1'b0);
        check("nom_busy", busy_v[0], 1'b0);
        check("nom_starts", gen_dut[0].start_n, 3);
        check("nom_acks", gen_dut[0].ack_n, 9);
        check("nom_bytes", gen_dut[0].byte_n, 9);
        for (int i = 0; i < 9; i++)
            check($sformatf("nom_byte%0d", i), gen_dut[0].log_b[i], exp_nom[i]);

        wait_done(1, 2000, cyc);
        check("halt_err", err_v[1], 1'b1);
        check("halt_err_index", gen_dut[1].err_index, 8'd1);
        check("halt_starts", gen_dut[1].start_n, 4);
        check("halt_bytes", gen_dut[1].byte_n, 6);

        wait_done(2, 2000, cyc);
        check("skip_err", err_v[2], 1'b1);
        check("skip_err_index", gen_dut[2].err_index, 8'd1);
        check("skip_starts", gen_dut[2].start_n, 5);
        for (int i = 0; i < 3; i++)
            check($sformatf("skip_entry2_byte%0d", i), gen_dut[2].log_b[6 + i], exp_nom[6 + i]);

        wait_done(3, 2000, cyc);
        check("wide_err", err_v[3], 1'b0);
        check("wide_acks", gen_dut[3].ack_n, 5);
        check("wide_bytes", gen_dut[3].byte_n, 5);
        for (int i = 0; i < 5; i++)
            check($sformatf("wide_byte%0d", i), gen_dut[3].log_b[i], exp_wide[i]);

        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        check("restart_clears_err", {done_v[1], err_v[1], busy_v[1], gen_dut[1].err_index}, 11'b001_0000_0000);

        sb = gen_dut[0].start_n;
        bb = gen_dut[0].byte_n;
        nack_lo[0] = sb + 2;
        nack_hi[0] = sb + 3;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        check("restart_done_clear", {done_v[0], busy_v[0], gen_dut[0].idx}, 10'b01_0000_0000);

        cyc = 0;
        while (gen_dut[0].idx != 8'd1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("reach_index1", gen_dut[0].idx, 8'd1);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        @(negedge clk);
        check("start_ignored_busy", {busy_v[0], gen_dut[0].idx}, 9'h101);

        wait_done(0, 3000, cyc);
        check("retry_err", err_v[0], 1'b0);
        check("retry_starts", gen_dut[0].start_n - sb, 5);
        check("retry_bytes", gen_dut[0].byte_n - bb, 11);
        for (int i = 0; i < 3; i++)
            check($sformatf("retry_entry2_byte%0d", i), gen_dut[0].log_b[8'(bb + 8 + i)], exp_nom[6 + i]);

        nack_lo[0] = 1;
        nack_hi[0] = 0;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (30) @(negedge clk);
        check("pre_reset_scl_high", {busy_v[0], gen_dut[0].scl}, 2'b11);
        rst[0] = 1'b1;
        @(negedge clk);
        check("midreset_outputs", {gen_dut[0].scl, gen_dut[0].sda_oe, busy_v[0], done_v[0]}, 4'b1000);
        rst[0] = 1'b0;
        sb = gen_dut[0].start_n;
        bb = gen_dut[0].byte_n;
        ab = gen_dut[0].ack_n;
        @(negedge clk);
        check("midreset_autostart", busy_v[0], 1'b1);
        wait_done(0, 2000, cyc);
        check("midreset_err", err_v[0], 1'b0);
        check("midreset_starts", gen_dut[0].start_n - sb, 3);
        check("midreset_acks", gen_dut[0].ack_n - ab, 9);
        for (int i = 0; i < 9; i++)
            check($sformatf("midreset_byte%0d", i), gen_dut[0].log_b[8'(bb + i)], exp_nom[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/i2c_cfg_sequencer.md
# i2c_cfg_sequencer

Table-driven I2C write sequencer. It is the parametrised successor to the team's fixed audio/video codec configuration block. It walks an external register table of LUT_SIZE entries and writes each one to the I2C bus. Sub-address width and data width are configurable, and every entry carries its own slave address. NACKed transfers are retried up to a bounded count, and the block reports done/error status to the host. It sits between the system clock domain and the board I2C pins, and drives all codec, decoder and sensor setup after reset or on a host re-trigger.

## Interface
Parameters:
- CLK_FREQ, 50000000: iCLK frequency in Hz.
- I2C_FREQ, 20000: SCL frequency in Hz.
- LUT_SIZE, 51: number of table entries, 1..255.
- ADDR_BYTES, 1: sub-address bytes per entry, 1 or 2.
- DATA_BYTES, 1: data bytes per entry, 1 or 2.
- MAX_RETRY, 3: retries per entry after a NACK, 0..15.
- SKIP_ON_ERR, 0: 1 = continue with the next entry after retries are exhausted; 0 = halt.

Ports:
- iCLK in 1: system clock. One clock domain for the whole block.
- iRST in 1: synchronous, active-high reset.
- iSTART in 1: one-cycle pulse that (re)starts the sequence from index 0. Ignored while oBUSY=1.
- oLUT_INDEX out 8: current table index.
- iLUT_DATA in 8+8*(ADDR_BYTES+DATA_BYTES): entry content, MSB first, laid out as {slave[7:1], x, subaddr, data}. Must be valid 1 cycle after oLUT_INDEX changes.
- oBUSY out 1: sequence in progress.
- oDONE out 1: sequence finished. Sticky until the next iSTART or iRST.
- oERR out 1: at least one entry exhausted its retries. Sticky until the next iSTART or iRST.
- oERR_INDEX out 8: index of the first failed entry.
- oI2C_SCLK out 1: SCL, push-pull.
- oSDA_OE out 1: 1 = pull SDA low.
- iSDA in 1: SDA pin readback.

## Operation
- After iRST deasserts, the sequence starts automatically, exactly as if iSTART had been pulsed.
- Bit timing: a quarter-tick fires every Q = CLK_FREQ/(4*I2C_FREQ) iCLK cycles (integer divide, minimum 1). Each SCL bit spans 4 ticks: tick 0 SCL low and SDA changes; tick 1 SCL rises; tick 2 SDA is sampled (ACK bit only); tick 3 SCL falls.
- States: IDLE → FETCH (1 cycle, latches iLUT_DATA) → START → SHIFT → ACK → (next byte ? SHIFT : STOP) → GAP → FETCH/IDLE.
- The bit-8 R/W value is forced to 0; the table's bit 0 is ignored. Bytes go out MSB first: slave, then sub-address byte(s) high first, then data byte(s) high first.
- START: SDA falls while SCL is high, then SCL falls.
- STOP: SDA rises while SCL is high.
- GAP: 4 ticks of bus idle between transfers.
- ACK phase releases SDA (oSDA_OE=0). iSDA=1 at tick 2 is a NACK; the rest of the transfer is aborted and the block goes straight to STOP.
- NACK handling: the retry counter increments and the same entry is retried. If the counter exceeds MAX_RETRY:
  - set oERR;
  - load oERR_INDEX, only if oERR was 0;
  - then either advance (SKIP_ON_ERR=1) or go to IDLE with oDONE=1 (SKIP_ON_ERR=0).
- The retry counter clears whenever the index advances.
- After the last entry (index LUT_SIZE-1) completes its STOP and GAP: oDONE=1, oBUSY=0, state IDLE.
- iSTART while oBUSY=0: clears oDONE, oERR and oERR_INDEX; index 0; oBUSY=1 on the next cycle.

## Timing
- Reset values: oBUSY=0, oDONE=0, oERR=0, oERR_INDEX=0, oLUT_INDEX=0, oI2C_SCLK=1, oSDA_OE=0. The tick divider and retry counter are 0, state IDLE.
- The auto-start makes oBUSY=1 on the first cycle after reset deasserts.
- iRST mid-transfer: outputs return to reset values on the next edge. The bus is released without a STOP; slaves recover on the next START.
- Transfer length: one byte = 9 bits = 36 ticks. One entry with no NACK = 4 (START) + 36*(1+ADDR_BYTES+DATA_BYTES) + 4 (STOP) + 4 (GAP) ticks, plus 1 FETCH cycle.
- oLUT_INDEX is stable from FETCH until the entry finishes, including all retries.
- oDONE and oBUSY change in the same cycle.

## Test plan
- Nominal: CLK_FREQ=800000, I2C_FREQ=100000 (Q=2), LUT_SIZE=3, 1+1 bytes, slave model ACKs everything.
  - Bench decodes writes (0x34,0x00,0x18), (0x34,0x02,0x77), (0x40,0xC3,0x01).
  - oDONE rises at cycle 3*(4+108+8)*2 + 3 ±2 after reset; oERR=0.
- Width: ADDR_BYTES=2, DATA_BYTES=2, entry 0x42_1234_ABCD → bytes 0x42,0x12,0x34,0xAB,0xCD; 5 ACK phases.
- Retry: slave NACKs the address of entry 1 twice, then ACKs, with MAX_RETRY=3 → three STARTs for entry 1, oERR=0, oDONE=1.
- Exhaustion: entry 1 is always NACKed, MAX_RETRY=2.
  - SKIP_ON_ERR=0: 3 attempts, then oDONE=1, oERR=1, oERR_INDEX=1, and entry 2 is never sent.
  - SKIP_ON_ERR=1: entry 2 is sent and oERR_INDEX stays 1.
- Restart: after oDONE, pulse iSTART → oDONE and oERR clear, the sequence replays from index 0. An iSTART pulse during oBUSY has no effect.
- Reset mid-byte: assert iRST during the 3rd bit of entry 0 → next cycle oI2C_SCLK=1, oSDA_OE=0, oBUSY=0. After release, a full sequence completes.
